date_validator: RTL

DATE_VALIDATOR -- requirements
Module: date_validator

---
 rtl/date_validator.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/date_validator.sv
// Streaming date-string checker for Y<sep>M<sep>D<NUL> with a registered verdict and first-error code.
// Optional leap-year February checking is enabled with the DATE_VALIDATOR_LEAP_EN macro.
module date_validator #(
  parameter int YEAR_MAX_DIGITS = 4,
  parameter int ALLOW_MIXED_SEP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char,
  output logic       result,
  output logic       done,
  output logic [2:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_YEAR, S_MONTH, S_DAY, S_ACCEPT, S_REJECT
  } state_e;

  localparam logic [2:0] ERR_YEAR  = 3'd1;
  localparam logic [2:0] ERR_SEP   = 3'd2;
  localparam logic [2:0] ERR_MONTH = 3'd3;
  localparam logic [2:0] ERR_DAY   = 3'd4;
  localparam logic [2:0] ERR_END   = 3'd5;

  state_e      state_q, state_d;
  logic [2:0]  err_q, err_d;
  logic [2:0]  ycnt_q, ycnt_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  sep1_q, sep1_d;
  logic [4:0]  month_q, month_d;
  logic [4:0]  day_q, day_d;
  logic [4:0]  feb_days, day_max;

  logic       is_digit, is_sep, is_nul;
  logic [3:0] digit;

  assign is_digit = (char >= 8'h30) && (char <= 8'h39);
  assign is_sep   = (char == 8'h2e) || (char == 8'h2d) || (char == 8'h2f);
  assign is_nul   = (char == 8'h00);
  assign digit    = char[3:0];

  // A two-digit value above 31 can never be a legal month or day, so it collapses
  // to 0, which both field checks already reject.
  function automatic logic [4:0] acc2(input logic [4:0] v, input logic [3:0] d);
    logic [6:0] s;
    s = {2'b00, v} * 7'd10 + {3'b000, d};
    return (s > 7'd31) ? 5'd0 : s[4:0];
  endfunction

`ifdef DATE_VALIDATOR_LEAP_EN
  logic [13:0] year_q, year_d;
  logic        leap;
  assign leap = ((year_q[1:0] == 2'b00) && ((year_q % 14'd100) != 14'd0)) ||
                ((year_q % 14'd400) == 14'd0);
  assign feb_days = leap ? 5'd29 : 5'd28;
`else
  assign feb_days = 5'd29;
`endif

  always_comb begin
    day_max = 5'd31;
    case (month_q)
      5'd2:                       day_max = feb_days;
      5'd4, 5'd6, 5'd9, 5'd11:    day_max = 5'd30;
      default:                    day_max = 5'd31;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ycnt_d  = ycnt_q;
    cnt_d   = cnt_q;
    sep1_d  = sep1_q;
    month_d = month_q;
    day_d   = day_q;
`ifdef DATE_VALIDATOR_LEAP_EN
    year_d  = year_q;
`endif
    if (char_valid) begin
      case (state_q)
        S_IDLE: begin
          if (is_nul) begin
            state_d = S_REJECT; err_d = ERR_END;
          end else if (is_digit && (char != 8'h30)) begin
            state_d = S_YEAR; ycnt_d = 3'd1;
`ifdef DATE_VALIDATOR_LEAP_EN
            year_d  = {10'd0, digit};
`endif
          end else begin
            state_d = S_REJECT; err_d = ERR_YEAR;
          end
        end
        S_YEAR: begin
          if (is_digit) begin
            if (ycnt_q < 3'(YEAR_MAX_DIGITS)) begin
              ycnt_d = ycnt_q + 3'd1;
`ifdef DATE_VALIDATOR_LEAP_EN
              year_d = year_q * 14'd10 + {10'd0, digit};
`endif
            end else begin
              state_d = S_REJECT; err_d = ERR_YEAR;
            end
          end else if (is_sep) begin
            state_d = S_MONTH; sep1_d = char; cnt_d = 2'd0;
          end else if (is_nul) begin
            state_d = S_REJECT; err_d = ERR_END;
          end else begin
            state_d = S_REJECT; err_d = ERR_YEAR;
          end
        end
        S_MONTH: begin
          if (is_digit) begin
            if (cnt_q < 2'd2) begin
              month_d = acc2(month_q, digit); cnt_d = cnt_q + 2'd1;
            end else begin
              state_d = S_REJECT; err_d = ERR_MONTH;
            end
          end else if (is_nul) begin
            state_d = S_REJECT; err_d = ERR_END;
          end else if (is_sep) begin
            if ((cnt_q == 2'd0) || ((ALLOW_MIXED_SEP == 0) && (char != sep1_q))) begin
              state_d = S_REJECT; err_d = ERR_SEP;
            end else if ((month_q == 5'd0) || (month_q > 5'd12)) begin
              state_d = S_REJECT; err_d = ERR_MONTH;
            end else begin
              state_d = S_DAY; cnt_d = 2'd0;
            end
          end else begin
            // Anything else where a separator was due counts as a separator fault.
            state_d = S_REJECT; err_d = ERR_SEP;
          end
        end
        S_DAY: begin
          if (is_digit) begin
            if (cnt_q < 2'd2) begin
              day_d = acc2(day_q, digit); cnt_d = cnt_q + 2'd1;
            end else begin
              state_d = S_REJECT; err_d = ERR_DAY;
            end
          end else if (is_nul) begin
            if (cnt_q == 2'd0) begin
              state_d = S_REJECT; err_d = ERR_END;
            end else if ((day_q != 5'd0) && (day_q <= day_max)) begin
              state_d = S_ACCEPT;
            end else begin
              state_d = S_REJECT; err_d = ERR_DAY;
            end
          end else begin
            state_d = S_REJECT; err_d = ERR_DAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= 3'd0;
      ycnt_q  <= 3'd0;
      cnt_q   <= 2'd0;
      sep1_q  <= 8'd0;
      month_q <= 5'd0;
      day_q   <= 5'd0;
`ifdef DATE_VALIDATOR_LEAP_EN
      year_q  <= 14'd0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ycnt_q  <= ycnt_d;
      cnt_q   <= cnt_d;
      sep1_q  <= sep1_d;
      month_q <= month_d;
      day_q   <= day_d;
`ifdef DATE_VALIDATOR_LEAP_EN
      year_q  <= year_d;
`endif
    end
  end

  assign done     = (state_q == S_ACCEPT) || (state_q == S_REJECT);
  assign result   = (state_q == S_ACCEPT);
  assign err_code = err_q;

endmodule
